// File: rtl/fifo_fwft_reader_pkg.sv
// Shared constants and helpers for the FWFT read front end of the dual-clock FIFO.
package fifo_fwft_reader_pkg;

  localparam int FWFT_DATA_WIDTH = 8;
  localparam int BUF_DEPTH       = 2;
  localparam int BUF_CNT_W       = 2;

  typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

  // Local occupancy (buffered + in flight, minus this cycle's pop) must stay below the buffer depth.
  function automatic logic has_room(buf_cnt_t cnt, logic inflight, logic pop);
    logic [BUF_CNT_W:0] occ;
    occ = {1'b0, cnt} + {{BUF_CNT_W{1'b0}}, inflight} - {{BUF_CNT_W{1'b0}}, pop};
    return occ < (BUF_CNT_W+1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_fwft_reader_if.sv
// Storage-side read port plus downstream valid/ready stream of the FWFT reader.
interface fifo_fwft_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data_out, flush, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data_out, flush, m_ready,
    input  fifo_r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_skid_buf2.sv
// Two-entry ordered buffer: head feeds the stream, tail is the skid slot.
module fifo_skid_buf2
  import fifo_fwft_reader_pkg::*;
#(
  parameter int DATA_WIDTH = FWFT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output buf_cnt_t              cnt_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  buf_cnt_t              cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        // Count unchanged; the head moves to the oldest remaining word.
        2'b11: begin
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      assert (cnt_q <= buf_cnt_t'(BUF_DEPTH));
      assert (!(push_i && !pop_i && !flush_i && cnt_q == buf_cnt_t'(BUF_DEPTH)));
    end
  end

  always_ff @(posedge clk_i) begin
    tail_q <= tail_d;
  end

  assign head_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_fwft_reader.sv
// FWFT read front end: issues storage reads, absorbs the 1-cycle read latency, streams words out.
// Optional delivered-word counter enabled by defining FIFO_READER_WORD_CNT_EN.
module fifo_fwft_reader
  import fifo_fwft_reader_pkg::*;
#(
  parameter int DATA_WIDTH = FWFT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  fifo_fwft_reader_if.master   bus,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  push;
  logic                  r_en;
  logic                  valid;
  logic [DATA_WIDTH-1:0] head;
  buf_cnt_t              cnt;

  assign pop  = valid & bus.m_ready;
  assign r_en = !rrst & !bus.flush & !bus.fifo_empty & has_room(cnt, inflight_q, pop);
  // A response landing in the flush cycle belongs to the discarded stream.
  assign push       = inflight_q & !bus.flush;
  assign inflight_d = r_en;

  always_ff @(posedge rclk) begin
    if (rrst) inflight_q <= 1'b0;
    else      inflight_q <= inflight_d;
  end

  fifo_skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i   (rclk),
    .rst_i   (rrst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .din_i   (bus.fifo_data_out),
    .head_o  (head),
    .valid_o (valid),
    .cnt_o   (cnt)
  );

  assign bus.fifo_r_en = r_en;
  assign bus.m_valid   = valid;
  assign bus.m_data    = head;

`ifdef FIFO_READER_WORD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  assign word_cnt_d = pop ? word_cnt_q + 1'b1 : word_cnt_q;

  always_ff @(posedge rclk) begin
    if (rrst) word_cnt_q <= '0;
    else      word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = '0;
`endif

endmodule
